// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: width codes, FSM states
// and the small store/legality helpers used by the control path.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, ACCESS, ERR, RESP} state_e;

  // Width codes that have no meaning for the given direction.
  function automatic logic f3_illegal(logic we, logic [2:0] f3);
    if (we) return (f3 > F3_W);
    return (f3 == 3'd3) || (f3 > F3_HU);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(logic [2:0] f3, logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Drop the low address bits a wider access cannot use.
  function automatic logic [1:0] force_align(logic [2:0] f3, logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return {off[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return off;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(logic [2:0] f3, logic [1:0] off);
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return 4'b0011 << {off[1], 1'b0};
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [31:0] store_repl(logic [2:0] f3, logic [31:0] wdata);
    case (f3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU-side request/response bundle of the data-memory controller.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl_load_align_ext.sv
// Load lane select and sign/zero extension; purely combinational.
module load_align_ext (
  input  logic [3:0][7:0] data_in,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [31:0]     result
);
  import dmem_pkg::*;

  logic [7:0]  b;
  logic [15:0] h;

  // Pick the addressed byte/halfword, then extend per width code.
  always_comb begin
    b = data_in[off];
    h = off[1] ? {data_in[3], data_in[2]} : {data_in[1], data_in[0]};
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_BU:   result = {24'd0, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_HU:   result = {16'd0, h};
      F3_W:    result = data_in;
      default: result = 32'd0;
    endcase
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one load/store at a time between MEM stage and a
// word-addressed synchronous RAM with MEM_LATENCY-cycle reads.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned accesses report an error;
// without it the low address bits are forced aligned and the access proceeds.
module data_mem_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int MEM_LATENCY = 1,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_ctrl_if.slave    bus,
  output logic [3:0]        MemWriteEnable,
  output logic [ADDR_W-3:0] addr_out,
  output logic [31:0]       data_out,
  input  logic [31:0]       data_in
);
  import dmem_pkg::*;

  if (DATA_W != 32 || MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_param_err
    $error("data_mem_ctrl: DATA_W must be 32 and MEM_LATENCY 1..4");
  end

  localparam logic [1:0] LAST = 2'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-3:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              bad;
  logic [31:0]       ld_data;
  logic              store_acc;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

  load_align_ext u_ld (
    .data_in (data_in),
    .off     (off_q),
    .funct3  (f3_q),
    .result  (ld_data)
  );

  // Next-state and request latching; load data captured on the last ACCESS cycle.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    bad     = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        we_d    = bus.req_we;
        f3_d    = bus.req_funct3;
        waddr_d = bus.req_addr[ADDR_W-1:2];
        wdata_d = bus.req_wdata;
        cnt_d   = 2'd0;
        err_d   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        off_d   = bus.req_addr[1:0];
        bad     = f3_illegal(bus.req_we, bus.req_funct3) |
                  misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
        off_d   = force_align(bus.req_funct3, bus.req_addr[1:0]);
        bad     = f3_illegal(bus.req_we, bus.req_funct3);
`endif
        state_d = bad ? ERR : ACCESS;
      end
      ACCESS: begin
        if (we_q) begin
          rdata_d = 32'd0;
          state_d = RESP;
        end else if (cnt_q == LAST) begin
          rdata_d = ld_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ERR: begin
        err_d   = 1'b1;
        rdata_d = 32'd0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
      cnt_q   <= 2'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write strobes exist only in the single store ACCESS cycle.
  assign store_acc      = (state_q == ACCESS) && we_q;
  assign MemWriteEnable = store_acc ? byte_mask(f3_q, off_q) : 4'b0000;
  assign data_out       = store_acc ? store_repl(f3_q, wdata_q) : 32'd0;
  assign addr_out       = waddr_q;

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_err    = err_q;
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data-memory controller between the pipeline MEM stage and a synchronous word-addressed data RAM. Accepts one load/store request at a time via valid/ready and generates per-byte write enables with lane-replicated store data. Tolerates a configurable RAM read latency, then aligns and sign/zero-extends load data. Returns a one-cycle response pulse carrying data or an error flag.

Parameters:
ADDR_W, 12, byte-address width seen by RAM; word address is addr[ADDR_W-1:2]
MEM_LATENCY, 1, RAM read latency in cycles, legal 1..4; data_in valid MEM_LATENCY cycles after addr_out
DATA_W, 32, data width; only 32 supported (elaboration error otherwise)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU request valid
req_ready  out  1  controller can accept request
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32 width code: 0 B, 1 H, 2 W, 4 BU, 5 HU
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits used for B/H)
rsp_valid  out  1  response pulse, one cycle
rsp_rdata  out  32  aligned/extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or illegal funct3; valid with rsp_valid
MemWriteEnable  out  4  per-byte RAM write enable
addr_out  out  ADDR_W-2  RAM word address
data_out  out  32  RAM write data
data_in  in  32  RAM read data

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, MemWriteEnable=0, addr_out=0, data_out=0, counter=0.
- FSM IDLE -> ACCESS -> RESP -> IDLE; ERR state for rejected requests.
- IDLE: req_ready=1 only here. Accept on req_valid&&req_ready: latch we, funct3, addr[1:0], word address, wdata.
- Legality: illegal funct3 = loads 3,6,7; stores any value >2. Misaligned = H/HU with addr[0]=1, W with addr[1:0]!=0. Illegal or misaligned -> ERR for 1 cycle (no RAM access, MemWriteEnable stays 0) -> RESP with rsp_err=1, rsp_rdata=0.
- ACCESS: addr_out = latched word address.
  - Store: exactly 1 cycle. MemWriteEnable = SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111. data_out = SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
  - Load: MEM_LATENCY cycles, counted by counter; MemWriteEnable=0. At end of the last ACCESS cycle, data_in is sampled, lane-selected by addr[1:0], extended (B/H sign, BU/HU zero) and registered into rsp_rdata.
- RESP: rsp_valid=1 for one cycle; then IDLE.
- Latency, accept edge to rsp_valid high: store 2 cycles, load MEM_LATENCY+1 cycles, error 2 cycles. Max throughput 1 request per MEM_LATENCY+2 cycles.
- MemWriteEnable is nonzero only during a store ACCESS cycle, never more than one cycle per store.
- rsp_rdata holds its value until the next response; rsp_err is cleared on the next accept.
- rst mid-operation: return to IDLE next edge. Any in-flight store write enable is deasserted from the next cycle, with no response. A write enable already presented before the rst edge is not rolled back.
- req_valid while not ready: ignored; the requester holds it.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined: misaligned accesses take the ERR path as above.
- Undefined: no misalignment check. Low address bits are forced aligned (H ignores addr[0], W ignores addr[1:0]) and the access proceeds normally. rsp_err then reports only illegal funct3.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State enum: IDLE, ACCESS, ERR, RESP.
  - Functions: byte-mask generation, store replication.
- Sub-module load_align_ext: combinational; inputs data_in, addr[1:0], funct3; output 32-bit extended result.

Test Plan:
- Reset, MEM_LATENCY=1: SW addr 0x010 wdata 0xDEADBEEF -> next cycle MemWriteEnable=4'b1111, addr_out=4, data_out=0xDEADBEEF; rsp_valid one cycle later, rsp_err=0.
- SB addr 0x013 wdata 0x000000A5 -> MemWriteEnable=4'b1000, data_out=0xA5A5A5A5, for exactly one cycle.
- RAM word 0x80FF7F01, MEM_LATENCY=3: LB addr+1 -> rsp_rdata=0x0000007F; LB addr+3 -> 0xFFFFFF80; LHU addr+2 -> 0x000080FF; LH addr+2 -> 0xFFFF80FF. Each rsp_valid arrives 4 cycles after accept.
- With DMEM_MISALIGN_TRAP_EN, LW addr 0x002 -> no RAM write, rsp_valid 2 cycles after accept with rsp_err=1, rsp_rdata=0. Without the macro, the same request reads word 0 and rsp_err=0.
- funct3=3 load -> rsp_err=1; funct3=4 store -> rsp_err=1, MemWriteEnable stays 0.
- Back-to-back: req_valid held high across 3 loads -> req_ready low during ACCESS/RESP, each request accepted exactly once. Assert rst during a load's ACCESS -> no rsp_valid, outputs return to reset values next cycle.
